// File: rtl/spi_pkg.sv
// Shared constants for the SPI slave port: register map, status/control bit positions, word size.
// Purely declarative; no logic, no latency.
package spi_pkg;

  localparam int DATABITS = 8;

  localparam logic [2:0] ADDR_RXDATA  = 3'd0;
  localparam logic [2:0] ADDR_TXDATA  = 3'd1;
  localparam logic [2:0] ADDR_STATUS  = 3'd2;
  localparam logic [2:0] ADDR_CONTROL = 3'd3;

  localparam int ST_UNR  = 9;
  localparam int ST_E    = 8;
  localparam int ST_RRDY = 7;
  localparam int ST_TRDY = 6;
  localparam int ST_IDLE = 5;
  localparam int ST_TOE  = 4;
  localparam int ST_ROE  = 3;

  // Control holds one irq enable per status bit, 9..3.
  localparam logic [15:0] IRQ_MASK = 16'h03F8;

endpackage

// File: rtl/spi_sync.sv
// N-flop synchronizer for one async pin, with single-cycle rise/fall pulses on the synchronized level.
// Latency STAGES clk to sync_out; edge pulses coincide with sync_out changing; no backpressure.
module spi_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
      prev  <= chain[STAGES-1];
    end
  end

  assign sync_out = chain[STAGES-1];
  assign rise     = sync_out & ~prev;
  assign fall     = ~sync_out & prev;

endmodule

// File: rtl/spi_slave_port.sv
// SPI mode-0 slave with an Avalon-MM register port (rxdata/txdata/status/control) and irq.
// Reads return data 2 clk after the request; SPI flags update 1 clk after the synchronized edge; no backpressure.
module spi_slave_port #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        spi_select,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [2:0]  mem_addr,
  input  logic [15:0] data_from_cpu,
  output logic [15:0] data_to_cpu,
  output logic        irq,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  output logic        miso_oe
);
  import spi_pkg::*;

  localparam logic [1:0]          FLUSH_LAST = 2'(SYNC_STAGES);
  localparam logic [2:0]          LAST_BIT   = 3'(DATABITS - 1);

  logic sclk_rise, sclk_fall;
  logic ss_s, ss_fall;
  logic mosi_s;

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset_n(reset_n), .async_in(SCLK),
    .sync_out(), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk(clk), .reset_n(reset_n), .async_in(SS_n),
    .sync_out(ss_s), .rise(), .fall(ss_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset_n(reset_n), .async_in(MOSI),
    .sync_out(mosi_s), .rise(), .fall()
  );

  // CPU access strobes fire once, on the first cycle of a request.
  logic        rd_req, wr_req, rd_prev, wr_prev, rd_strb, wr_strb;
  logic [2:0]  addr_q;
  logic [15:0] wdata_q;

  assign rd_req = spi_select & ~read_n;
  assign wr_req = spi_select & ~write_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_prev <= 1'b0;
      wr_prev <= 1'b0;
      rd_strb <= 1'b0;
      wr_strb <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      rd_prev <= rd_req;
      wr_prev <= wr_req;
      rd_strb <= rd_req & ~rd_prev;
      wr_strb <= wr_req & ~wr_prev;
      addr_q  <= mem_addr;
      wdata_q <= data_from_cpu;
    end
  end

  logic wr_tx, wr_st, wr_ctl, rd_rx;
  assign wr_tx  = wr_strb && (addr_q == ADDR_TXDATA);
  assign wr_st  = wr_strb && (addr_q == ADDR_STATUS);
  assign wr_ctl = wr_strb && (addr_q == ADDR_CONTROL);
  assign rd_rx  = rd_strb && (addr_q == ADDR_RXDATA);

  // A synchronizer coming out of reset can show a false SS_n fall while the pin is
  // held low; frames are ignored until SS_n has been seen high on flushed flops.
  logic [1:0] flush_cnt;
  logic       armed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flush_cnt <= '0;
      armed     <= 1'b0;
    end else if (flush_cnt != FLUSH_LAST) begin
      flush_cnt <= flush_cnt + 2'd1;
    end else if (ss_s) begin
      armed <= 1'b1;
    end
  end

  logic                active, load, byte_last;
  logic [DATABITS-1:0] shift_reg, rx_hold, tx_hold, rx_byte;
  logic [DATABITS-2:0] acc;
  logic [2:0]          bitcnt;
  logic                tx_primed, rrdy, roe, toe, unr, unr_pend;
  logic [15:0]         ctrl, status;

  assign active    = armed & ~ss_s;
  assign load      = (ss_fall & armed) | (sclk_fall & active & (bitcnt == 3'd0));
  assign byte_last = (bitcnt == LAST_BIT);
  assign rx_byte   = {acc, mosi_s};

  // Clears precede sets in this block so that a coinciding flag event wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg <= '0;
      rx_hold   <= '0;
      tx_hold   <= '0;
      acc       <= '0;
      bitcnt    <= '0;
      tx_primed <= 1'b0;
      rrdy      <= 1'b0;
      roe       <= 1'b0;
      toe       <= 1'b0;
      unr       <= 1'b0;
      unr_pend  <= 1'b0;
      ctrl      <= '0;
    end else begin
      if (wr_st) begin
        rrdy <= 1'b0;
        roe  <= 1'b0;
        toe  <= 1'b0;
        unr  <= 1'b0;
      end
      if (rd_rx)
        rrdy <= 1'b0;
      if (wr_ctl)
        ctrl <= wdata_q & IRQ_MASK;

      if (wr_tx) begin
        if (!tx_primed) begin
          tx_hold   <= wdata_q[DATABITS-1:0];
          tx_primed <= 1'b1;
        end else begin
          toe <= 1'b1;
        end
      end

      // An empty reload at a byte boundary only counts as underrun if the
      // master goes on to clock that byte; the trailing SCLK fall of a frame
      // always lands on a boundary.
      if (load) begin
        if (tx_primed) begin
          shift_reg <= tx_hold;
          tx_primed <= 1'b0;
        end else begin
          shift_reg <= '0;
          if (ss_fall)
            unr <= 1'b1;
          else
            unr_pend <= 1'b1;
        end
      end else if (sclk_fall && active) begin
        shift_reg <= {shift_reg[DATABITS-2:0], 1'b0};
      end

      if (!active) begin
        bitcnt   <= '0;
        unr_pend <= 1'b0;
      end else if (sclk_rise) begin
        acc    <= rx_byte[DATABITS-2:0];
        bitcnt <= bitcnt + 3'd1;
        if (unr_pend) begin
          unr      <= 1'b1;
          unr_pend <= 1'b0;
        end
        if (byte_last) begin
          rx_hold <= rx_byte;
          rrdy    <= 1'b1;
          if (rrdy)
            roe <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    status          = '0;
    status[ST_UNR]  = unr;
    status[ST_E]    = roe | toe | unr;
    status[ST_RRDY] = rrdy;
    status[ST_TRDY] = ~tx_primed;
    status[ST_IDLE] = ss_s;
    status[ST_TOE]  = toe;
    status[ST_ROE]  = roe;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_to_cpu <= '0;
      irq         <= 1'b0;
    end else begin
      irq <= |(status & ctrl);
      if (rd_strb) begin
        case (addr_q)
          ADDR_RXDATA:  data_to_cpu <= {{(16-DATABITS){1'b0}}, rx_hold};
          ADDR_STATUS:  data_to_cpu <= status;
          ADDR_CONTROL: data_to_cpu <= ctrl;
          default:      data_to_cpu <= '0;
        endcase
      end
    end
  end

  assign MISO    = shift_reg[DATABITS-1];
  assign miso_oe = active;

endmodule

// File: doc/spi_slave_port.md
SPI_SLAVE_PORT -- requirements
Module: spi_slave_port

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth on SCLK/SS_n/MOSI (legal 2..3).
REQ-002 SHALL have ports: clk  in  1  system clock (50 MHz); one clock, all logic on its rising edge.
REQ-003 SHALL have ports: reset_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports: spi_select in 1, read_n in 1, write_n in 1, mem_addr in 3, data_from_cpu in 16; Avalon-MM slave inputs.
REQ-005 SHALL have ports: data_to_cpu out 16 (registered read data); irq out 1 (registered interrupt).
REQ-006 SHALL have ports: SCLK in 1, SS_n in 1, MOSI in 1 (asynchronous SPI pins); MISO out 1; miso_oe out 1 (high = drive MISO).

Function
REQ-007 SHALL implement SPI mode 0 (CPOL=0, CPHA=0), 8-bit words, MSB first; SCLK SHALL be at most clk/8.
REQ-008 SHALL pass SCLK, SS_n, MOSI through SYNC_STAGES flops; edge detection SHALL use the synchronized signals only.
REQ-009 SHALL use register map: 0 rxdata (r, bits 7:0), 1 txdata (w), 2 status (r; any write clears RRDY, ROE, TOE, UNR), 3 control (r/w irq enables at status bit positions).
REQ-010 SHALL lay out status as: bit9 UNR, bit8 E = ROE|TOE|UNR, bit7 RRDY, bit6 TRDY, bit5 IDLE (synchronized SS_n high), bit4 TOE, bit3 ROE; other bits 0.
REQ-011 SHALL treat a read/write as two-cycle: strobe registered on the first cycle of spi_select & ~read_n / ~write_n; data_to_cpu valid the cycle after the strobe.
REQ-012 SHALL set TRDY = ~tx_primed; a txdata write with TRDY=1 loads tx_hold <= data_from_cpu[7:0] and sets tx_primed; a write with TRDY=0 sets TOE and leaves tx_hold unchanged.
REQ-013 On synchronized SS_n falling edge, SHALL load shift_reg from tx_hold and clear tx_primed if primed; otherwise SHALL load 0x00 and set UNR.
REQ-014 SHALL drive MISO = shift_reg[7] and miso_oe = ~SS_n(synchronized), so bit 7 is valid before the first SCLK rise.
REQ-015 On each synchronized SCLK rising edge with SS_n low, SHALL sample MOSI into the bit accumulator and increment bitcnt (3 bits, wraps 7->0).
REQ-016 On the 8th rising edge, SHALL write the assembled byte to rx_hold, set RRDY, and set ROE if RRDY was already 1 (rx_hold overwritten).
REQ-017 On each SCLK falling edge, SHALL shift shift_reg left by 1; if bitcnt==0 (byte boundary) SHALL instead reload per REQ-013 for back-to-back bytes.
REQ-018 SHALL make RRDY visible 1 clk after the synchronized edge (SYNC_STAGES+1 clk after the pin edge).
REQ-019 An rxdata read SHALL clear RRDY; if byte completion coincides, set wins (RRDY stays 1, new byte in rx_hold).
REQ-020 A txdata write coinciding with a shift_reg load SHALL go to tx_hold: load uses the pre-write tx_primed state, and the written byte stays primed.
REQ-021 SS_n rising mid-byte SHALL clear bitcnt, discard partial bits, not set RRDY; the consumed tx byte SHALL NOT be restored.
REQ-022 A status write coinciding with a flag-setting event SHALL leave the flag set (set wins).
REQ-023 SHALL register irq = OR over (status bit & control enable) for bits 9..3, one clk after the flag change.

Reset
REQ-024 On reset_n low, SHALL clear: data_to_cpu=0, irq=0, MISO=0, miso_oe=0, shift_reg, rx_hold, tx_hold, tx_primed, bitcnt, all flags, control=0; synchronizer flops SHALL reset to idle levels (SCLK 0, SS_n 1, MOSI 0).
REQ-025 Reset asserted mid-transfer SHALL abort the transfer; after release the block SHALL wait for a fresh SS_n falling edge.

Structure
REQ-026 Package spi_pkg SHALL hold register address constants, status/control bit indices, and DATABITS=8.
REQ-027 Sub-module spi_sync (N-stage synchronizer plus rise/fall pulse outputs) SHALL be instantiated for SCLK, SS_n, and MOSI (edges unused for MOSI).

Verification
REQ-028 Write txdata 0xA5, then master sends 0x3C at clk/10 -> MISO shows 10100101, rxdata reads 0x3C, RRDY 1->0 after read, no error flags.
REQ-029 Master sends 2 bytes in one SS_n frame with no tx written -> MISO 0x00 both bytes, UNR=1, irq=1 when control bit9=1.
REQ-030 Master sends 0x11 then 0x22 without CPU read -> rxdata=0x22, ROE=1, E=1; status write -> ROE=0, RRDY=0.
REQ-031 Write txdata twice before any transfer -> TOE=1, tx_hold keeps first byte; next transfer shifts out the first byte.
REQ-032 SS_n deasserted after 4 SCLK -> RRDY stays 0, next full frame receives the correct byte; reset_n pulse mid-byte -> all outputs at reset values.
